// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider-sharing controller.
package div_ctrl_pkg;

    localparam int NW = 16;
    localparam int DW = 8;

    // Quotient reported when the divisor is zero.
    localparam logic [DW-1:0] DZ_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above
// last_grant, wrapping around to the lowest index when none is above it.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] upper_req;
    logic [NREQ-1:0] pick_src;

    // Mask of requesters strictly above the previous winner.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign upper_mask[gi] = (IDW'(gi) > last_grant);
        end
    endgenerate

    // Lowest set bit of the upper half if any, otherwise of the full vector.
    always_comb begin
        upper_req = req & upper_mask;
        pick_src  = (|upper_req) ? upper_req : req;
        grant     = '0;
        grant_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
        grant_any = |req;
    end

endmodule

// File: rtl/div_array_share_ctrl.sv
// Shares one combinational 16/8 divider array between NREQ requesters:
// round-robin grant, registered operands held for SETTLE cycles, then a
// tagged response held until the consumer accepts it.
module div_array_share_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 2,
    parameter int IDW    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NW*NREQ-1:0]   req_n,
    input  logic [DW*NREQ-1:0]   req_d,
    output logic [NW-1:0]        div_n,
    output logic [DW-1:0]        div_d,
    input  logic [DW-1:0]        div_q,
    input  logic [DW-1:0]        div_r,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [DW-1:0]        rsp_q,
    output logic [DW-1:0]        rsp_r,
    output logic                 rsp_dz,
    output logic                 rsp_ovf,
    output logic                 busy
);

    // The settle counter only ever holds SETTLE-1 down to 0.
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    generate
        if (SETTLE < 1) begin : g_bad_settle
            $error("div_array_share_ctrl: SETTLE must be at least 1");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("div_array_share_ctrl: NREQ must be in 2..8");
        end
        if (IDW != $clog2(NREQ)) begin : g_bad_idw
            $error("div_array_share_ctrl: IDW must equal clog2(NREQ)");
        end
    endgenerate

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [IDW-1:0]  last_grant_reg;

    logic [NW-1:0]   req_n_arr [NREQ];
    logic [DW-1:0]   req_d_arr [NREQ];
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic [NW-1:0]   sel_n;
    logic [DW-1:0]   sel_d;

    // Unpack the flat operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign req_n_arr[gi] = req_n[NW*gi +: NW];
            assign req_d_arr[gi] = req_d[DW*gi +: DW];
        end
    endgenerate

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign sel_n = req_n_arr[grant_idx];
    assign sel_d = req_d_arr[grant_idx];

    // Accept pulses exist only while idle; everything else ignores requesters.
    assign req_ready = (state_reg == ST_IDLE) ? grant : '0;
    assign rsp_valid = (state_reg == ST_RESP);
    assign busy      = (state_reg != ST_IDLE);

    // Sequencer: grant and latch operands, wait for the array, hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            last_grant_reg <= IDW'(NREQ - 1);
            div_n          <= '0;
            div_d          <= '0;
            rsp_id         <= '0;
            rsp_q          <= '0;
            rsp_r          <= '0;
            rsp_dz         <= 1'b0;
            rsp_ovf        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        div_n          <= sel_n;
                        div_d          <= sel_d;
                        rsp_id         <= grant_idx;
                        last_grant_reg <= grant_idx;
                        if (sel_d == '0) begin
                            // Divider output is meaningless here; answer directly.
                            rsp_q     <= DZ_QUOT;
                            rsp_r     <= sel_n[DW-1:0];
                            rsp_dz    <= 1'b1;
                            rsp_ovf   <= 1'b0;
                            state_reg <= ST_RESP;
                        end else begin
                            rsp_dz    <= 1'b0;
                            rsp_ovf   <= (sel_n[NW-1:DW] >= sel_d);
                            cnt_reg   <= CW'(SETTLE - 1);
                            state_reg <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == '0) begin
                        rsp_q     <= div_q;
                        rsp_r     <= div_r;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_array_share_ctrl.sv
// Bench for div_array_share_ctrl: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level timing model.
module tb_div_array_share_ctrl;

    localparam int NREQ   = 4;
    localparam int SETTLE = 2;
    localparam int IDW    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      tv = '0;
    logic [NREQ-1:0]      req_ready;
    logic [15:0]          tn [NREQ];
    logic [7:0]           td [NREQ];
    logic [16*NREQ-1:0]   req_n_bus;
    logic [8*NREQ-1:0]    req_d_bus;
    logic [15:0]          div_n;
    logic [7:0]           div_d;
    logic [7:0]           div_q;
    logic [7:0]           div_r;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [7:0]           rsp_q;
    logic [7:0]           rsp_r;
    logic                 rsp_dz;
    logic                 rsp_ovf;
    logic                 busy;

    always #5 clk = ~clk;

    div_array_share_ctrl #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE),
        .IDW    (IDW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (tv),
        .req_ready (req_ready),
        .req_n     (req_n_bus),
        .req_d     (req_d_bus),
        .div_n     (div_n),
        .div_d     (div_d),
        .div_q     (div_q),
        .div_r     (div_r),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dz    (rsp_dz),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    // Pack per-requester operands onto the flat buses.
    always_comb begin
        req_n_bus = '0;
        req_d_bus = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_n_bus[16*i +: 16] = tn[i];
            req_d_bus[8*i +: 8]   = td[i];
        end
    end

    // Exact divider array; garbage on divide-by-zero so the DUT must ignore it.
    always_comb begin
        if (div_d == 8'd0) begin
            div_q = 8'hA5;
            div_r = 8'h5A;
        end else begin
            div_q = 8'(div_n / {8'd0, div_d});
            div_r = 8'(div_n % {8'd0, div_d});
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level, timestamps in cycles).
    int  m_cycle = 0;
    bit  m_busy = 0;
    int  m_resp_cycle = 0;
    int  m_last = NREQ - 1;
    int  m_granted = -1;
    int  m_id, m_q, m_r, m_dz, m_ovf;
    int  m_div_n = 0;
    int  m_div_d = 0;
    bit  rand_mode = 0;

    // Observations used by directed scenarios.
    int  obs_grant_cyc = 0;
    int  obs_grant_idx = -1;
    int  obs_rsp_cyc = 0;
    bit  prev_rsp = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cycle);
        end
    endtask

    // Compare DUT outputs with the model for this cycle, then advance the
    // model as the coming clock edge will.
    task automatic model_check();
        logic [NREQ-1:0] exp_ready;
        int  g;
        bit  exp_rsp;
        int  n, d;
        exp_ready = '0;
        g = -1;
        exp_rsp = m_busy && (m_cycle >= m_resp_cycle);
        if (!m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && tv[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        check("div_n", 32'(div_n), m_div_n);
        check("div_d", 32'(div_d), m_div_d);
        if (exp_rsp) begin
            check("rsp_id", 32'(rsp_id), m_id);
            check("rsp_q", 32'(rsp_q), m_q);
            check("rsp_r", 32'(rsp_r), m_r);
            check("rsp_dz", 32'(rsp_dz), m_dz);
            check("rsp_ovf", 32'(rsp_ovf), m_ovf);
        end

        if (req_ready != '0) begin
            obs_grant_cyc = m_cycle;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) obs_grant_idx = i;
        end
        if (rsp_valid && !prev_rsp) obs_rsp_cyc = m_cycle;
        prev_rsp = rsp_valid;
        if (rsp_valid && rsp_ready)
            $display("rsp cycle=%0d id=%0d q=%02h r=%02h dz=%0b ovf=%0b",
                     m_cycle, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf);

        m_granted = -1;
        if (g >= 0) begin
            n = int'(tn[g]);
            d = int'(td[g]);
            m_busy    = 1;
            m_div_n   = n;
            m_div_d   = d;
            m_id      = g;
            m_last    = g;
            m_granted = g;
            if (d == 0) begin
                m_q = 255; m_r = n % 256; m_dz = 1; m_ovf = 0;
                m_resp_cycle = m_cycle + 1;
            end else begin
                m_q = (n / d) % 256; m_r = (n % d) % 256; m_dz = 0;
                m_ovf = ((n / 256) >= d) ? 1 : 0;
                m_resp_cycle = m_cycle + SETTLE + 1;
            end
        end else if (exp_rsp && rsp_ready) begin
            m_busy = 0;
        end
        m_cycle++;
    endtask

    // Start a cycle: the requester accepted at the last edge withdraws.
    task automatic begin_cycle();
        @(negedge clk);
        if (m_granted >= 0) tv[m_granted] = 1'b0;
    endtask

    task automatic end_cycle();
        #1;
        model_check();
    endtask

    task automatic gen_random_inputs();
        for (int i = 0; i < NREQ; i++) begin
            if (tv[i] && ($urandom % 32 == 0)) begin
                tv[i] = 1'b0;
            end else if (!tv[i] && ($urandom % 3 == 0)) begin
                tv[i] = 1'b1;
                tn[i] = 16'($urandom);
                case ($urandom % 8)
                    0:       td[i] = 8'd0;
                    1, 2:    td[i] = 8'($urandom_range(1, 15));
                    default: td[i] = 8'($urandom);
                endcase
            end
        end
        rsp_ready = 1'($urandom % 2);
    endtask

    task automatic plain_cycle();
        begin_cycle();
        if (rand_mode) gen_random_inputs();
        end_cycle();
    endtask

    task automatic wait_rsp(input int budget, output bit seen);
        for (int k = 0; k < budget && !rsp_valid; k++) plain_cycle();
        seen = rsp_valid;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (busy || m_busy); k++) begin
            begin_cycle();
            tv = '0;
            rsp_ready = 1'b1;
            end_cycle();
        end
        check("drain_idle", 32'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tv = '0;
        rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_div_n", 32'(div_n), 0);
        check("rst_div_d", 32'(div_d), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_q", 32'(rsp_q), 0);
        check("rst_rsp_r", 32'(rsp_r), 0);
        check("rst_rsp_dz", 32'(rsp_dz), 0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        m_busy = 0; m_last = NREQ - 1; m_div_n = 0; m_div_d = 0;
        m_granted = -1; prev_rsp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_check();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int t0, ng;
        int order [5];
        logic [7:0] hold_q, hold_r;

        for (int i = 0; i < NREQ; i++) begin tn[i] = '0; td[i] = '0; end
        do_reset();

        // Single exact request from requester 1.
        begin_cycle(); tv[1] = 1'b1; tn[1] = 16'd200; td[1] = 8'd10; rsp_ready = 1'b1; end_cycle();
        t0 = obs_grant_cyc;
        check("t1_grant_idx", 32'(obs_grant_idx), 1);
        wait_rsp(20, seen);
        check("t1_rsp_seen", 32'(seen), 1);
        check("t1_latency", 32'(obs_rsp_cyc - t0), 3);
        check("t1_id", 32'(rsp_id), 1);
        check("t1_q", 32'(rsp_q), 20);
        check("t1_r", 32'(rsp_r), 0);

        // Divide by zero.
        begin_cycle(); tv[0] = 1'b1; tn[0] = 16'h1234; td[0] = 8'd0; end_cycle();
        t0 = obs_grant_cyc;
        wait_rsp(20, seen);
        check("dz_latency", 32'(obs_rsp_cyc - t0), 1);
        check("dz_q", 32'(rsp_q), 32'hFF);
        check("dz_r", 32'(rsp_r), 32'h34);
        check("dz_flag", 32'(rsp_dz), 1);

        // Quotient overflow: flag only, quotient passed through.
        begin_cycle(); tv[2] = 1'b1; tn[2] = 16'h0A00; td[2] = 8'h05; end_cycle();
        wait_rsp(20, seen);
        check("ovf_flag", 32'(rsp_ovf), 1);
        check("ovf_q", 32'(rsp_q), 32'h00);
        check("ovf_dz", 32'(rsp_dz), 0);

        // Fairness with all requesters continuously valid.
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) order[k] = 99;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            begin_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (!tv[i]) begin
                    tv[i] = 1'b1; tn[i] = 16'($urandom); td[i] = 8'($urandom_range(1, 255));
                end
            end
            end_cycle();
            if (req_ready != '0) begin order[ng] = obs_grant_idx; ng++; end
        end
        for (int k = 0; k < 5; k++) check("fair_order", 32'(order[k]), 32'(k % NREQ));
        drain();

        // Backpressure: response held for 5 cycles while others wait.
        begin_cycle(); rsp_ready = 1'b0; tv[3] = 1'b1; tn[3] = 16'd1000; td[3] = 8'd7; end_cycle();
        begin_cycle(); tv[0] = 1'b1; tn[0] = 16'd50; td[0] = 8'd3; tv[1] = 1'b1; tn[1] = 16'd9; td[1] = 8'd2; end_cycle();
        wait_rsp(20, seen);
        check("bp_rsp_seen", 32'(seen), 1);
        hold_q = rsp_q; hold_r = rsp_r;
        check("bp_q", 32'(hold_q), 142);
        check("bp_r", 32'(hold_r), 6);
        ng = 0;
        for (int k = 0; k < 5; k++) begin
            plain_cycle();
            if (req_ready != '0) ng++;
            check("bp_q_stable", 32'(rsp_q), 32'(hold_q));
            check("bp_r_stable", 32'(rsp_r), 32'(hold_r));
        end
        check("bp_no_grant", 32'(ng), 0);
        begin_cycle(); rsp_ready = 1'b1; end_cycle();
        check("bp_handshake_no_grant", 32'(req_ready), 0);
        plain_cycle();
        check("bp_grant_after", 32'(req_ready != '0), 1);
        drain();

        // Reset while requester 2 is in SETTLE.
        begin_cycle(); tv[2] = 1'b1; tn[2] = 16'd77; td[2] = 8'd5; end_cycle();
        check("mid_grant_idx", 32'(obs_grant_idx), 2);
        plain_cycle();
        do_reset();
        begin_cycle(); tv[1] = 1'b1; tn[1] = 16'd300; td[1] = 8'd20; tv[3] = 1'b1; tn[3] = 16'd5; td[3] = 8'd5; rsp_ready = 1'b1; end_cycle();
        check("post_rst_grant", 32'(obs_grant_idx), 1);
        wait_rsp(20, seen);
        check("post_rst_id", 32'(rsp_id), 1);
        drain();

        // Random traffic.
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) plain_cycle();
        rand_mode = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
